// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and constants for the translation lookaside buffer.
// Holds the entry layout, the satp CSR view and the default geometry.
// No logic, no latency; consumed by tlb_if, tlb_cam and tlb.
package tlb_pkg;

  localparam int TLB_ENTRIES = 8;
  localparam int TLB_VPN_W   = 27;
  localparam int TLB_PPN_W   = 44;

  // One cached translation: VPN tag (va[38:12]) to PPN (pa[55:12]).
  typedef struct packed {
    logic                 valid;
    logic [TLB_VPN_W-1:0] vpn;
    logic [TLB_PPN_W-1:0] ppn;
  } tlb_entry_t;

  // RV64 satp layout: MODE[63:60], ASID[59:44], PPN[43:0].
  typedef struct packed {
    logic [3:0]  mode;
    logic [15:0] asid;
    logic [43:0] ppn;
  } satp_t;

  localparam logic [3:0] SATP_MODE_BARE = 4'd0;
  localparam logic [3:0] SATP_MODE_SV39 = 4'd8;
  localparam logic [1:0] PRIV_M         = 2'b11;

  // Translation is skipped entirely in bare mode or when running in M-mode.
  function automatic logic is_bypass(input satp_t satp, input logic [1:0] priv);
    return (satp.mode == SATP_MODE_BARE) || (priv == PRIV_M);
  endfunction

endpackage

// File: rtl/tlb_if.sv
// tlb_if: request/response, walker handshake and control bundle for tlb.
// Ports: req_*/resp_* (requester), walk_* (page-table walker), flush/satp/mmode.
// The slave modport is the TLB's view; master is the requester/walker side.
// Optional TLB_STATS_EN adds hit_cnt/miss_cnt driven by the TLB.
interface tlb_if;
  import tlb_pkg::*;

  logic        req_valid;
  logic [63:0] req_va;
  logic        resp_valid;
  logic [63:0] resp_pa;
  logic        resp_fault;
  logic        walk_en;
  logic [63:0] walk_va;
  logic        walk_done;
  logic [63:0] walk_pa;
  logic        walk_valid_pte;
  logic        flush;
  satp_t       satp;
  logic [1:0]  mmode;
`ifdef TLB_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  modport slave (
    input  req_valid, req_va, walk_done, walk_pa, walk_valid_pte, flush, satp, mmode,
    output resp_valid, resp_pa, resp_fault, walk_en, walk_va
`ifdef TLB_STATS_EN
    , output hit_cnt, miss_cnt
`endif
  );

  modport master (
    output req_valid, req_va, walk_done, walk_pa, walk_valid_pte, flush, satp, mmode,
    input  resp_valid, resp_pa, resp_fault, walk_en, walk_va
`ifdef TLB_STATS_EN
    , input hit_cnt, miss_cnt
`endif
  );

endinterface

// File: rtl/tlb_cam.sv
// tlb_cam: parallel tag compare of one VPN against every TLB entry.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: i_entries (entry array), i_vpn (lookup tag), o_hit, o_ppn (matched PPN).
module tlb_cam
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES
) (
  input  tlb_entry_t [ENTRIES-1:0] i_entries,
  input  logic [TLB_VPN_W-1:0]     i_vpn,
  output logic                     o_hit,
  output logic [TLB_PPN_W-1:0]     o_ppn
);

  // Fills only follow misses, so at most one entry matches; OR-ing the
  // matched PPNs therefore yields the single hit without a priority encoder.
  always_comb begin
    o_hit = 1'b0;
    o_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (i_entries[i].valid && (i_entries[i].vpn == i_vpn)) begin
        o_hit = 1'b1;
        o_ppn = o_ppn | i_entries[i].ppn;
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// tlb: fully-associative TLB in front of the Sv39 page-table walker.
// Latency: bypass same cycle, hit 1 cycle after acceptance, miss = walk + 1.
// Backpressure: requester holds req_valid until resp_valid, then drops it for >=1 cycle.
// Ports: clk, reset (sync, active-high), tlb_bus (tlb_if.slave).
// Optional macro TLB_STATS_EN: saturating hit_cnt/miss_cnt on the interface.
module tlb
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int VPN_W   = TLB_VPN_W,
  parameter int PPN_W   = TLB_PPN_W
) (
  input logic  clk,
  input logic  reset,
  tlb_if.slave tlb_bus
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_WALK   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  tlb_entry_t [ENTRIES-1:0] r_entries;
  logic [PTR_W-1:0]         r_ptr;
  logic [63:0]              r_walk_va;
  logic                     r_walk_flushed;

  logic             w_bypass;
  logic [VPN_W-1:0] w_vpn;
  logic             w_cam_hit;
  logic [PPN_W-1:0] w_cam_ppn;
  logic             w_lookup_hit;
  logic             w_lookup_miss;
  logic             w_fill;

  assign w_bypass = is_bypass(tlb_bus.satp, tlb_bus.mmode);
  assign w_vpn    = tlb_bus.req_va[12 +: VPN_W];

  tlb_cam #(.ENTRIES(ENTRIES)) u_cam (
    .i_entries (r_entries),
    .i_vpn     (w_vpn),
    .o_hit     (w_cam_hit),
    .o_ppn     (w_cam_ppn)
  );

  // A flush in the lookup cycle must not return a translation it is invalidating.
  assign w_lookup_hit  = (r_state == ST_LOOKUP) && w_cam_hit && !tlb_bus.flush;
  assign w_lookup_miss = (r_state == ST_LOOKUP) && !w_lookup_hit;

  // A flush seen at any point of the walk (sticky flag or this cycle) drops the fill.
  assign w_fill = (r_state == ST_WALK) && tlb_bus.walk_done && tlb_bus.walk_valid_pte &&
                  !tlb_bus.flush && !r_walk_flushed;

  always_comb begin
    tlb_bus.resp_valid = 1'b0;
    tlb_bus.resp_pa    = '0;
    tlb_bus.resp_fault = 1'b0;
    w_state_nxt        = r_state;
    case (r_state)
      ST_IDLE: begin
        if (tlb_bus.req_valid) begin
          if (w_bypass) begin
            tlb_bus.resp_valid = 1'b1;
            tlb_bus.resp_pa    = tlb_bus.req_va;
          end else begin
            w_state_nxt = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        if (w_lookup_hit) begin
          tlb_bus.resp_valid = 1'b1;
          tlb_bus.resp_pa    = 64'({w_cam_ppn, tlb_bus.req_va[11:0]});
          w_state_nxt        = ST_RESP;
        end else begin
          w_state_nxt = ST_WALK;
        end
      end
      ST_WALK: begin
        if (tlb_bus.walk_done) begin
          tlb_bus.resp_valid = 1'b1;
          tlb_bus.resp_pa    = tlb_bus.walk_pa;
          tlb_bus.resp_fault = !tlb_bus.walk_valid_pte;
          w_state_nxt        = ST_RESP;
        end
      end
      default: begin
        if (!tlb_bus.req_valid) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign tlb_bus.walk_en = (r_state == ST_WALK);
  assign tlb_bus.walk_va = r_walk_va;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_entries      <= '0;
      r_ptr          <= '0;
      r_walk_va      <= '0;
      r_walk_flushed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lookup_miss) r_walk_va <= tlb_bus.req_va;

      if (r_state == ST_LOOKUP)                      r_walk_flushed <= 1'b0;
      else if (r_state == ST_WALK && tlb_bus.flush)  r_walk_flushed <= 1'b1;

      if (tlb_bus.flush) begin
        for (int i = 0; i < ENTRIES; i++) r_entries[i].valid <= 1'b0;
      end else if (w_fill) begin
        r_entries[r_ptr] <= '{valid: 1'b1,
                              vpn:   r_walk_va[12 +: VPN_W],
                              ppn:   tlb_bus.walk_pa[12 +: PPN_W]};
        r_ptr <= (r_ptr == PTR_W'(ENTRIES - 1)) ? '0 : r_ptr + 1'b1;
      end
    end
  end

`ifdef TLB_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Counters survive flush; only reset clears them. Both stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_lookup_hit  && (r_hit_cnt  != 32'hFFFF_FFFF)) r_hit_cnt  <= r_hit_cnt  + 32'd1;
      if (w_lookup_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign tlb_bus.hit_cnt  = r_hit_cnt;
  assign tlb_bus.miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_tlb.sv
// tb_tlb: self-checking bench for tlb with a queue-based reference model.
// The model holds cached translations in fill order; capacity overflow evicts the oldest.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_tlb;
  import tlb_pkg::*;

  localparam int ENTRIES = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_if u_if();

  tlb #(.ENTRIES(ENTRIES)) dut (
    .clk     (clk),
    .reset   (reset),
    .tlb_bus (u_if)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: translations in fill order, plus lookup statistics.
  logic [26:0] m_vpn[$];
  logic [43:0] m_ppn[$];
  int          m_hits;
  int          m_misses;

  function automatic int m_find(input logic [26:0] vpn);
    for (int i = 0; i < m_vpn.size(); i++) if (m_vpn[i] == vpn) return i;
    return -1;
  endfunction

  task automatic m_clear();
    m_vpn.delete();
    m_ppn.delete();
  endtask

  task automatic m_fill(input logic [26:0] vpn, input logic [43:0] ppn);
    m_vpn.push_back(vpn);
    m_ppn.push_back(ppn);
    if (m_vpn.size() > ENTRIES) begin
      void'(m_vpn.pop_front());
      void'(m_ppn.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    u_if.flush = 1'b1;
    step();
    u_if.flush = 1'b0;
    m_clear();
  endtask

  // One complete request. flush_at: 0 none, 1 lookup cycle, 2 first walk cycle, 3 done cycle.
  task automatic txn(input logic [63:0] va, input logic [63:0] wpa, input bit vpte,
                     input int delay, input int flush_at);
    bit          byp;
    bit          fl_walk;
    int          idx;
    logic [63:0] exp_pa;
    byp = (u_if.satp.mode == 4'd0) || (u_if.mmode == 2'b11);
    u_if.req_valid = 1'b1;
    u_if.req_va    = va;
    @(negedge clk);
    if (byp) begin
      n_vec++;
      if (u_if.resp_valid !== 1'b1 || u_if.resp_pa !== va || u_if.resp_fault !== 1'b0 ||
          u_if.walk_en !== 1'b0) begin
        n_err++;
        $display("FAIL bypass va=%h: vld=%b pa=%h flt=%b wen=%b, want vld=1 pa=%h flt=0 wen=0",
                 va, u_if.resp_valid, u_if.resp_pa, u_if.resp_fault, u_if.walk_en, va);
      end
      step();
      u_if.req_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (u_if.resp_valid !== 1'b0 || u_if.walk_en !== 1'b0) begin
        n_err++;
        $display("FAIL bypass_after va=%h: vld=%b wen=%b, want 0 0", va, u_if.resp_valid, u_if.walk_en);
      end
      step();
      return;
    end
    n_vec++;
    if (u_if.resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL accept_cycle va=%h: resp_valid=%b, want 0", va, u_if.resp_valid);
    end
    step();
    idx = m_find(va[38:12]);
    if (flush_at == 1) begin
      u_if.flush = 1'b1;
      m_clear();
      idx = -1;
    end
    @(negedge clk);
    if (idx >= 0) begin
      m_hits++;
      exp_pa = ({20'b0, m_ppn[idx]} << 12) | (va & 64'hFFF);
      n_vec++;
      if (u_if.resp_valid !== 1'b1 || u_if.resp_pa !== exp_pa || u_if.resp_fault !== 1'b0 ||
          u_if.walk_en !== 1'b0) begin
        n_err++;
        $display("FAIL hit va=%h: vld=%b pa=%h flt=%b wen=%b, want vld=1 pa=%h flt=0 wen=0",
                 va, u_if.resp_valid, u_if.resp_pa, u_if.resp_fault, u_if.walk_en, exp_pa);
      end
      step();
      u_if.req_valid = 1'b0;
    end else begin
      m_misses++;
      n_vec++;
      if (u_if.resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL miss_lookup va=%h: resp_valid=%b, want 0", va, u_if.resp_valid);
      end
      step();
      u_if.flush = 1'b0;
      fl_walk = 1'b0;
      for (int c = 0; c <= delay; c++) begin
        if (c == delay) begin
          u_if.walk_done      = 1'b1;
          u_if.walk_pa        = wpa;
          u_if.walk_valid_pte = vpte;
        end
        if ((flush_at == 2 && c == 0) || (flush_at == 3 && c == delay)) begin
          u_if.flush = 1'b1;
          fl_walk    = 1'b1;
        end
        @(negedge clk);
        n_vec++;
        if (u_if.walk_en !== 1'b1 || u_if.walk_va !== va) begin
          n_err++;
          $display("FAIL walk_hs va=%h: walk_en=%b walk_va=%h, want 1 %h", va, u_if.walk_en, u_if.walk_va, va);
        end
        n_vec++;
        if (c == delay) begin
          if (u_if.resp_valid !== 1'b1 || u_if.resp_pa !== wpa || u_if.resp_fault !== !vpte) begin
            n_err++;
            $display("FAIL walk_resp va=%h: vld=%b pa=%h flt=%b, want vld=1 pa=%h flt=%b",
                     va, u_if.resp_valid, u_if.resp_pa, u_if.resp_fault, wpa, !vpte);
          end
        end else if (u_if.resp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL walk_wait va=%h: resp_valid=%b, want 0", va, u_if.resp_valid);
        end
        step();
        u_if.flush     = 1'b0;
        u_if.walk_done = 1'b0;
      end
      if (fl_walk) m_clear();
      else if (vpte) m_fill(va[38:12], wpa[55:12]);
      u_if.req_valid = 1'b0;
    end
    @(negedge clk);
    n_vec++;
    if (u_if.resp_valid !== 1'b0 || u_if.walk_en !== 1'b0) begin
      n_err++;
      $display("FAIL resp_hold va=%h: vld=%b wen=%b, want 0 0", va, u_if.resp_valid, u_if.walk_en);
    end
    step();
  endtask

  task automatic test_reset();
    u_if.req_valid      = 1'b0;
    u_if.req_va         = '0;
    u_if.walk_done      = 1'b0;
    u_if.walk_pa        = '0;
    u_if.walk_valid_pte = 1'b0;
    u_if.flush          = 1'b0;
    u_if.satp           = '{mode: SATP_MODE_SV39, asid: 16'd0, ppn: 44'd0};
    u_if.mmode          = 2'b01;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_clear();
    m_hits = 0;
    m_misses = 0;
    @(negedge clk);
    n_vec++;
    if (u_if.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: %b want 0", u_if.resp_valid); end
    n_vec++;
    if (u_if.resp_pa !== 64'd0) begin n_err++; $display("FAIL reset_resp_pa: %h want 0", u_if.resp_pa); end
    n_vec++;
    if (u_if.resp_fault !== 1'b0) begin n_err++; $display("FAIL reset_resp_fault: %b want 0", u_if.resp_fault); end
    n_vec++;
    if (u_if.walk_en !== 1'b0) begin n_err++; $display("FAIL reset_walk_en: %b want 0", u_if.walk_en); end
    n_vec++;
    if (u_if.walk_va !== 64'd0) begin n_err++; $display("FAIL reset_walk_va: %h want 0", u_if.walk_va); end
    step();
  endtask

  task automatic test_bypass();
    u_if.satp.mode = SATP_MODE_BARE;
    txn(64'h8000_1234, 64'h0, 1'b1, 0, 0);
    u_if.satp.mode = SATP_MODE_SV39;
    u_if.mmode     = 2'b11;
    txn(64'h0000_0040_0000_1ABC, 64'h0, 1'b1, 0, 0);
    u_if.mmode     = 2'b01;
  endtask

  task automatic test_miss_hit();
    txn(64'h0000_0040_0000_1ABC, 64'h8020_3ABC, 1'b1, 2, 0);
    txn(64'h0000_0040_0000_1ABC, 64'h0, 1'b1, 0, 0);
    txn(64'h0000_0040_0000_1004, 64'h0, 1'b1, 0, 0);
  endtask

  task automatic test_invalid_pte();
    txn(64'h0000_0012_3456_7890, 64'h0000_0000_DEAD_0000, 1'b0, 1, 0);
    txn(64'h0000_0012_3456_7890, 64'h0000_0000_9000_0890, 1'b1, 0, 0);
    txn(64'h0000_0012_3456_7FF0, 64'h0, 1'b1, 0, 0);
  endtask

  task automatic test_wrap();
    logic [63:0] va;
    do_flush();
    for (int i = 0; i < ENTRIES + 1; i++) begin
      va = (64'(i + 100) << 12) | 64'h0A0;
      txn(va, (64'(i + 4000) << 12) | 64'h0A0, 1'b1, 0, 0);
    end
    for (int i = 1; i < ENTRIES + 1; i++) txn((64'(i + 100) << 12) | 64'h123, 64'h0, 1'b1, 0, 0);
    txn((64'd100 << 12) | 64'h123, 64'h0000_0000_7777_7123, 1'b1, 0, 0);
  endtask

  task automatic test_flush();
    txn(64'h0000_0001_0000_0010, 64'h0000_0000_A000_0010, 1'b1, 0, 0);
    do_flush();
    txn(64'h0000_0001_0000_0010, 64'h0000_0000_A100_0010, 1'b1, 0, 0);
    txn(64'h0000_0001_0000_0020, 64'h0, 1'b1, 0, 1);
    txn(64'h0000_0001_0000_0030, 64'h0, 1'b1, 0, 0);
    txn(64'h0000_0002_0000_0040, 64'h0000_0000_B000_0040, 1'b1, 2, 2);
    txn(64'h0000_0002_0000_0040, 64'h0000_0000_B100_0040, 1'b1, 1, 3);
    txn(64'h0000_0002_0000_0040, 64'h0000_0000_B200_0040, 1'b1, 0, 0);
  endtask

  task automatic test_reset_midwalk();
    txn(64'h0000_0003_0000_0050, 64'h0000_0000_C000_0050, 1'b1, 0, 0);
    u_if.req_valid = 1'b1;
    u_if.req_va    = 64'h0000_0004_0000_0060;
    step();
    step();
    @(negedge clk);
    n_vec++;
    if (u_if.walk_en !== 1'b1) begin n_err++; $display("FAIL midwalk_en: %b want 1", u_if.walk_en); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    u_if.req_valid = 1'b0;
    m_clear();
    m_hits = 0;
    m_misses = 0;
    @(negedge clk);
    n_vec++;
    if (u_if.walk_en !== 1'b0 || u_if.resp_valid !== 1'b0 || u_if.walk_va !== 64'd0) begin
      n_err++;
      $display("FAIL midwalk_reset: wen=%b vld=%b walk_va=%h, want 0 0 0", u_if.walk_en, u_if.resp_valid, u_if.walk_va);
    end
    step();
    txn(64'h0000_0003_0000_0050, 64'h0000_0000_C100_0050, 1'b1, 0, 0);
  endtask

  task automatic test_random();
    logic [63:0] va;
    logic [63:0] wpa;
    int          r;
    int          fa;
    for (int n = 0; n < 200; n++) begin
      va  = (64'($urandom_range(0, 11) + 512) << 12) | 64'($urandom_range(0, 4095));
      wpa = {$urandom, $urandom};
      r   = $urandom_range(0, 19);
      fa  = (r < 4) ? r : 0;
      if ($urandom_range(0, 19) == 0) do_flush();
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) u_if.satp.mode = SATP_MODE_BARE;
        else                           u_if.mmode     = 2'b11;
      end
      txn(va, wpa, ($urandom_range(0, 9) != 0), $urandom_range(0, 3), fa);
      u_if.satp.mode = SATP_MODE_SV39;
      u_if.mmode     = 2'b01;
    end
  endtask

`ifdef TLB_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    n_vec++;
    if (u_if.hit_cnt !== 32'(m_hits)) begin n_err++; $display("FAIL hit_cnt: %0d want %0d", u_if.hit_cnt, m_hits); end
    n_vec++;
    if (u_if.miss_cnt !== 32'(m_misses)) begin n_err++; $display("FAIL miss_cnt: %0d want %0d", u_if.miss_cnt, m_misses); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_bypass();
    test_miss_hit();
    test_invalid_pte();
    test_wrap();
    test_flush();
    test_reset_midwalk();
    test_random();
`ifdef TLB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
